ghash_pair_sched: RTL and testbench

GHASH_PAIR_SCHED -- requirements
Module: ghash_pair_sched

---
 rtl/ghash_pair_sched.sv | 164 ++++++++++++++++
 tb/tb_ghash_pair_sched.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghash_pair_sched.sv
// GHASH pair-beat issue scheduler: spaces accepted pair beats by the multiply/reduce latency.
// Optional macro GHASH_SCHED_STATS_EN adds a 32-bit issued-pair counter on o_pair_count.
//
// state  | meaning
// IDLE   | waiting for a key load and a start-of-message pair
// ISSUE  | mid-message, ready for the next pair
// SPACE  | waiting for the previous pair to clear the datapath
// DRAIN  | last pair issued, waiting for the tag to emerge
// DONE   | tag valid next cycle; pulse o_done and return to IDLE
module ghash_pair_sched #(
   parameter int NB_BLOCK = 128,
   parameter int N_BLOCKS = 2,
   parameter int NB_DATA  = N_BLOCKS*NB_BLOCK,
   parameter int PIPE_LAT = 4
`ifdef GHASH_SCHED_STATS_EN
   ,
   parameter logic [31:0] STATS_INIT = 32'h0
`endif
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic [NB_BLOCK-1:0] i_h_key,
   input  logic [NB_BLOCK-1:0] i_h_key2,
   input  logic                i_key_load,
   input  logic                i_valid,
   input  logic                i_sop,
   input  logic                i_eop,
   input  logic                i_last_odd,
   input  logic                i_stall_req,
   output logic                o_ready,
   output logic [NB_DATA-1:0]  o_h_pow_pair,
   output logic                o_fb_sel,
   output logic                o_valid,
   output logic                o_stall,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_err,
   output logic [31:0]         o_pair_count
);

   if (N_BLOCKS != 2 || NB_DATA != 2*NB_BLOCK) begin : g_bad_width
      $error("ghash_pair_sched supports exactly two blocks per beat");
   end
   if (PIPE_LAT < 2 || PIPE_LAT > 15) begin : g_bad_lat
      $error("ghash_pair_sched PIPE_LAT must be within 2..15");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_SPACE,
      S_DRAIN,
      S_DONE
   } state_t;

   // SPACE counts down to zero inclusive, so it holds PIPE_LAT-1 cycles; DRAIN holds PIPE_LAT.
   localparam logic [3:0] SPACE_LOAD = 4'(PIPE_LAT-2);
   localparam logic [3:0] DRAIN_LOAD = 4'(PIPE_LAT-1);

   state_t              state_q;
   logic [3:0]          cnt_q;
   logic                key_vld_q;
   logic [NB_BLOCK-1:0] h_q;
   logic [NB_BLOCK-1:0] h2_q;
   logic [NB_DATA-1:0]  pair_q;
   logic                fb_q;
   logic                valid_q;
   logic                stall_q;
   logic                done_q;
   logic                err_q;

   logic                ready_d;
   logic                accept;
   logic                issue;
   logic [NB_DATA-1:0]  pair_d;

   assign ready_d = !i_reset && !i_stall_req &&
                    ((state_q == S_IDLE && key_vld_q) || state_q == S_ISSUE);
   assign accept  = i_valid && ready_d;
   // Mid-message every accepted beat issues; a stray sop there restarts the message.
   assign issue   = accept && (state_q == S_ISSUE || i_sop);
   assign pair_d  = (i_eop && i_last_odd) ? {h_q, {NB_BLOCK{1'b0}}} : {h2_q, h_q};

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         key_vld_q <= 1'b0;
         h_q       <= '0;
         h2_q      <= '0;
         pair_q    <= '0;
         fb_q      <= 1'b0;
         valid_q   <= 1'b0;
         stall_q   <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         stall_q <= i_stall_req;

         if (state_q == S_IDLE && i_key_load) begin
            h_q       <= i_h_key;
            h2_q      <= i_h_key2;
            key_vld_q <= 1'b1;
         end

         if (!i_stall_req) begin
            case (state_q)
               S_IDLE: begin
                  if (accept && !i_sop) err_q <= 1'b1;
               end
               S_ISSUE: begin
                  if (accept && i_sop) err_q <= 1'b1;
               end
               S_SPACE: begin
                  if (cnt_q == 4'd0) state_q <= S_ISSUE;
                  else               cnt_q   <= cnt_q - 4'd1;
               end
               S_DRAIN: begin
                  if (cnt_q == 4'd0) state_q <= S_DONE;
                  else               cnt_q   <= cnt_q - 4'd1;
               end
               S_DONE: begin
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
               end
               default: state_q <= S_IDLE;
            endcase

            if (issue) begin
               valid_q <= 1'b1;
               fb_q    <= !i_sop;
               pair_q  <= pair_d;
               state_q <= i_eop ? S_DRAIN : S_SPACE;
               cnt_q   <= i_eop ? DRAIN_LOAD : SPACE_LOAD;
            end
         end
      end
   end

`ifdef GHASH_SCHED_STATS_EN
   logic [31:0] pair_cnt_q;

   always_ff @(posedge i_clock) begin
      if (i_reset)    pair_cnt_q <= STATS_INIT;
      else if (issue) pair_cnt_q <= pair_cnt_q + 32'd1;
   end

   assign o_pair_count = pair_cnt_q;
`else
   assign o_pair_count = 32'h0;
`endif

   assign o_ready      = ready_d;
   assign o_h_pow_pair = pair_q;
   assign o_fb_sel     = fb_q;
   assign o_valid      = valid_q;
   assign o_stall      = stall_q;
   assign o_busy       = (state_q != S_IDLE);
   assign o_done       = done_q;
   assign o_err        = err_q;

endmodule

// File: tb/tb_ghash_pair_sched.sv
// Self-checking bench for ghash_pair_sched: randomized messages against a cycle-count model.
module tb_ghash_pair_sched;
   localparam int NB_BLOCK = 128;
   localparam int NB_DATA  = 256;
   localparam int PIPE_LAT = 4;
`ifdef GHASH_SCHED_STATS_EN
   localparam logic [31:0] STATS_INIT = 32'hFFFF_FFFE;
   localparam bit          STATS      = 1'b1;
`else
   localparam logic [31:0] STATS_INIT = 32'h0;
   localparam bit          STATS      = 1'b0;
`endif

   logic                i_clock = 1'b0;
   logic                i_reset;
   logic [NB_BLOCK-1:0] i_h_key;
   logic [NB_BLOCK-1:0] i_h_key2;
   logic                i_key_load;
   logic                i_valid;
   logic                i_sop;
   logic                i_eop;
   logic                i_last_odd;
   logic                i_stall_req;
   logic                o_ready;
   logic [NB_DATA-1:0]  o_h_pow_pair;
   logic                o_fb_sel;
   logic                o_valid;
   logic                o_stall;
   logic                o_busy;
   logic                o_done;
   logic                o_err;
   logic [31:0]         o_pair_count;

   ghash_pair_sched #(
      .PIPE_LAT(PIPE_LAT)
`ifdef GHASH_SCHED_STATS_EN
      , .STATS_INIT(STATS_INIT)
`endif
   ) dut (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_h_key      (i_h_key),
      .i_h_key2     (i_h_key2),
      .i_key_load   (i_key_load),
      .i_valid      (i_valid),
      .i_sop        (i_sop),
      .i_eop        (i_eop),
      .i_last_odd   (i_last_odd),
      .i_stall_req  (i_stall_req),
      .o_ready      (o_ready),
      .o_h_pow_pair (o_h_pow_pair),
      .o_fb_sel     (o_fb_sel),
      .o_valid      (o_valid),
      .o_stall      (o_stall),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_err        (o_err),
      .o_pair_count (o_pair_count)
   );

   always #5 i_clock = ~i_clock;

   typedef struct {
      int                 stamp;
      logic [NB_DATA-1:0] pair;
      logic               fb;
   } issue_t;

   issue_t obs_q[$];
   issue_t exp_q[$];
   int     done_q[$];
   issue_t mon_r;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic [NB_BLOCK-1:0] key_a;
   logic [NB_BLOCK-1:0] key_b;
   bit                  exp_err = 1'b0;
   logic [31:0]         exp_cnt = STATS_INIT;

   always @(posedge i_clock) cyc <= cyc + 1;

   // Issues and done pulses are stamped with the number of rising edges seen so far.
   always @(negedge i_clock) begin
      if (o_valid) begin
         mon_r.stamp = cyc;
         mon_r.pair  = o_h_pow_pair;
         mon_r.fb    = o_fb_sel;
         obs_q.push_back(mon_r);
      end
      if (o_done) done_q.push_back(cyc);
   end

   function automatic logic [NB_BLOCK-1:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic step();
      @(posedge i_clock);
      #1;
   endtask

   task automatic load_key();
      key_a      = rnd128();
      key_b      = rnd128();
      i_h_key    = key_a;
      i_h_key2   = key_b;
      i_key_load = 1'b1;
      step();
      i_key_load = 1'b0;
      i_h_key    = rnd128();
      i_h_key2   = rnd128();
   endtask

   // Drives one message and scores it: a beat is accepted once PIPE_LAT-1 unstalled
   // edges have passed since the previous accept; done follows PIPE_LAT+1 unstalled edges
   // after the last accept.
   task automatic run_msg(input int n, input bit odd, input int gap_max, input int stall_pct,
                          input int restart_at, input int stall_beat, input int stall_w,
                          input int stall_len, input bit junk_key);
      int  w, frozen, target, thr, guard, exp_done;
      bit  st, acc, sop, exp_rdy;
      issue_t e;
      obs_q.delete();
      exp_q.delete();
      done_q.delete();
      w = 0;
      frozen = 0;
      for (int i = 0; i < n; i++) begin
         thr    = (i == 0) ? 0 : PIPE_LAT - 1;
         target = thr + ((i == 0) ? 0 : int'($urandom_range(0, gap_max)));
         sop    = (i == 0) || (i == restart_at);
         guard  = 0;
         acc    = 1'b0;
         while (!acc && guard < 200) begin
            st = ($urandom_range(0, 99) < stall_pct) ||
                 (i == stall_beat && w >= stall_w && w < stall_w + stall_len);
            i_stall_req = st;
            i_key_load  = junk_key && (i > 0) && ($urandom_range(0, 3) == 0);
            if (w - frozen >= target) begin
               i_valid    = 1'b1;
               i_sop      = sop;
               i_eop      = (i == n - 1);
               i_last_odd = odd;
            end else begin
               i_valid    = 1'b0;
               i_sop      = $urandom_range(0, 1);
               i_eop      = $urandom_range(0, 1);
               i_last_odd = $urandom_range(0, 1);
            end
            #1;
            exp_rdy = !st && (w - frozen >= thr);
            n_checks++;
            if (o_ready !== exp_rdy)
               $display("FAIL ready beat%0d w%0d: got %b expected %b", i, w, o_ready, exp_rdy);
            else n_pass++;
            acc = i_valid && !st;
            step();
            n_checks++;
            if (o_stall !== st) $display("FAIL stall_follow: got %b expected %b", o_stall, st);
            else n_pass++;
            if (st) frozen++;
            w++;
            guard++;
            if (acc) begin
               e.stamp = cyc;
               e.fb    = !sop;
               e.pair  = (i == n - 1 && odd) ? {key_a, 128'h0} : {key_b, key_a};
               exp_q.push_back(e);
               exp_cnt = exp_cnt + 32'd1;
               if (sop && i > 0) exp_err = 1'b1;
               w = 0;
               frozen = 0;
            end
         end
         if (!acc) begin
            n_checks++;
            $display("FAIL accept_timeout beat%0d: got no accept expected accept", i);
         end
      end
      i_valid = 1'b0;
      i_sop = 1'b0;
      i_eop = 1'b0;
      i_last_odd = 1'b0;
      guard = 0;
      while (w - frozen < PIPE_LAT + 1 && guard < 200) begin
         st = ($urandom_range(0, 99) < stall_pct);
         i_stall_req = st;
         i_key_load  = junk_key && ($urandom_range(0, 3) == 0);
         #1;
         n_checks++;
         if (o_busy !== 1'b1) $display("FAIL busy_drain: got %b expected 1", o_busy);
         else n_pass++;
         step();
         if (st) frozen++;
         w++;
         guard++;
      end
      i_stall_req = 1'b0;
      i_key_load  = 1'b0;
      exp_done    = cyc;
      @(negedge i_clock);
      #1;
      n_checks++;
      if (obs_q.size() !== exp_q.size())
         $display("FAIL issue_count: got %0d expected %0d", obs_q.size(), exp_q.size());
      else n_pass++;
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
         n_checks += 3;
         if (obs_q[k].stamp !== exp_q[k].stamp)
            $display("FAIL issue_time%0d: got %0d expected %0d", k, obs_q[k].stamp, exp_q[k].stamp);
         else n_pass++;
         if (obs_q[k].pair !== exp_q[k].pair)
            $display("FAIL issue_pair%0d: got %h expected %h", k, obs_q[k].pair, exp_q[k].pair);
         else n_pass++;
         if (obs_q[k].fb !== exp_q[k].fb)
            $display("FAIL issue_fb%0d: got %b expected %b", k, obs_q[k].fb, exp_q[k].fb);
         else n_pass++;
      end
      n_checks++;
      if (done_q.size() !== 1 || done_q[0] !== exp_done)
         $display("FAIL done_time: got %0d pulses first %0d expected 1 pulse at %0d",
                  done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, exp_done);
      else n_pass++;
      n_checks++;
      if (o_busy !== 1'b0) $display("FAIL busy_end: got %b expected 0", o_busy);
      else n_pass++;
      n_checks++;
      if (o_err !== exp_err) $display("FAIL err_msg: got %b expected %b", o_err, exp_err);
      else n_pass++;
      n_checks++;
      if (o_pair_count !== (STATS ? exp_cnt : 32'h0))
         $display("FAIL pair_count: got %h expected %h", o_pair_count, STATS ? exp_cnt : 32'h0);
      else n_pass++;
   endtask

   task automatic test_reset();
      i_reset = 1'b1;
      i_stall_req = 1'b1;
      repeat (3) step();
      n_checks++;
      if ({o_valid, o_ready, o_busy, o_done, o_err, o_stall, o_fb_sel} !== 7'b0)
         $display("FAIL reset_flags: got %b expected 0000000",
                  {o_valid, o_ready, o_busy, o_done, o_err, o_stall, o_fb_sel});
      else n_pass++;
      n_checks++;
      if (o_h_pow_pair !== '0) $display("FAIL reset_pair: got %h expected 0", o_h_pow_pair);
      else n_pass++;
      n_checks++;
      if (o_pair_count !== STATS_INIT)
         $display("FAIL reset_count: got %h expected %h", o_pair_count, STATS_INIT);
      else n_pass++;
      i_reset = 1'b0;
      i_stall_req = 1'b0;
      step();
   endtask

   task automatic test_no_key();
      obs_q.delete();
      i_valid = 1'b1;
      i_sop = 1'b1;
      i_eop = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         n_checks++;
         if (o_ready !== 1'b0) $display("FAIL nokey_ready: got %b expected 0", o_ready);
         else n_pass++;
         step();
      end
      i_valid = 1'b0;
      i_sop = 1'b0;
      i_eop = 1'b0;
      @(negedge i_clock);
      #1;
      n_checks++;
      if (obs_q.size() !== 0 || o_err !== 1'b0 || o_busy !== 1'b0)
         $display("FAIL nokey_idle: got %0d issues err %b busy %b expected 0 0 0",
                  obs_q.size(), o_err, o_busy);
      else n_pass++;
   endtask

`ifdef GHASH_SCHED_STATS_EN
   task automatic test_stats_wrap();
      load_key();
      run_msg(1, 0, 0, 0, -1, -1, 0, 0, 0);
      n_checks++;
      if (o_pair_count !== 32'hFFFF_FFFF) $display("FAIL stats_max: got %h expected ffffffff", o_pair_count);
      else n_pass++;
      run_msg(1, 1, 0, 0, -1, -1, 0, 0, 0);
      n_checks++;
      if (o_pair_count !== 32'h0) $display("FAIL stats_wrap: got %h expected 0", o_pair_count);
      else n_pass++;
   endtask
`endif

   task automatic test_three_pair();
      load_key();
      run_msg(3, 0, 0, 0, -1, -1, 0, 0, 0);
      n_checks++;
      if (obs_q.size() !== 3) $display("FAIL three_count: got %0d expected 3", obs_q.size());
      else n_pass++;
      if (obs_q.size() == 3 && done_q.size() == 1) begin
         n_checks += 3;
         if (obs_q[1].stamp - obs_q[0].stamp !== PIPE_LAT || obs_q[2].stamp - obs_q[1].stamp !== PIPE_LAT)
            $display("FAIL three_spacing: got %0d,%0d expected %0d", obs_q[1].stamp - obs_q[0].stamp,
                     obs_q[2].stamp - obs_q[1].stamp, PIPE_LAT);
         else n_pass++;
         if ({obs_q[0].fb, obs_q[1].fb, obs_q[2].fb} !== 3'b011)
            $display("FAIL three_fb: got %b%b%b expected 011", obs_q[0].fb, obs_q[1].fb, obs_q[2].fb);
         else n_pass++;
         if (done_q[0] !== obs_q[2].stamp + PIPE_LAT + 1)
            $display("FAIL three_done: got %0d expected %0d", done_q[0], obs_q[2].stamp + PIPE_LAT + 1);
         else n_pass++;
      end
   endtask

   task automatic test_single_odd();
      logic [NB_DATA-1:0] want;
      load_key();
      want = {key_a, 128'h0};
      run_msg(1, 1, 0, 0, -1, -1, 0, 0, 0);
      n_checks++;
      if (obs_q.size() !== 1 || obs_q[0].pair !== want || obs_q[0].fb !== 1'b0)
         $display("FAIL single_odd: got %0d issues pair %h expected 1 issue pair %h fb 0",
                  obs_q.size(), (obs_q.size() > 0) ? obs_q[0].pair : '0, want);
      else n_pass++;
   endtask

   task automatic test_stall();
      load_key();
      run_msg(2, 0, 0, 0, -1, 1, 1, 3, 0);
      n_checks++;
      if (obs_q.size() !== 2 || obs_q[1].stamp - obs_q[0].stamp !== PIPE_LAT + 3)
         $display("FAIL stall_delay: got %0d issues spacing %0d expected 2 issues spacing %0d",
                  obs_q.size(), (obs_q.size() == 2) ? obs_q[1].stamp - obs_q[0].stamp : -1, PIPE_LAT + 3);
      else n_pass++;
   endtask

   task automatic test_random();
      for (int m = 0; m < 8; m++) begin
         if (m % 2 == 0) load_key();
         run_msg(int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)), 2, 20, -1, -1, 0, 0, 1);
      end
   endtask

   task automatic test_restart();
      load_key();
      run_msg(4, 0, 1, 0, 2, -1, 0, 0, 0);
      n_checks++;
      if (obs_q.size() !== 4 || obs_q[2].fb !== 1'b0 || o_err !== 1'b1)
         $display("FAIL restart: got %0d issues err %b expected 4 issues, restart fb 0, err 1",
                  obs_q.size(), o_err);
      else n_pass++;
   endtask

   task automatic test_bad_sop();
      obs_q.delete();
      i_valid = 1'b1;
      i_sop = 1'b0;
      i_eop = 1'b1;
      #1;
      n_checks++;
      if (o_ready !== 1'b1) $display("FAIL badsop_ready: got %b expected 1", o_ready);
      else n_pass++;
      step();
      i_valid = 1'b0;
      i_eop = 1'b0;
      repeat (PIPE_LAT + 2) step();
      @(negedge i_clock);
      #1;
      n_checks++;
      if (obs_q.size() !== 0 || o_err !== 1'b1 || o_busy !== 1'b0)
         $display("FAIL badsop: got %0d issues err %b busy %b expected 0 1 0", obs_q.size(), o_err, o_busy);
      else n_pass++;
   endtask

   task automatic test_reset_drain();
      obs_q.delete();
      done_q.delete();
      i_valid = 1'b1;
      i_sop = 1'b1;
      i_eop = 1'b1;
      i_last_odd = 1'b0;
      step();
      i_valid = 1'b0;
      i_sop = 1'b0;
      i_eop = 1'b0;
      step();
      n_checks++;
      if (o_busy !== 1'b1) $display("FAIL drain_busy: got %b expected 1", o_busy);
      else n_pass++;
      i_reset = 1'b1;
      step();
      i_reset = 1'b0;
      exp_err = 1'b0;
      exp_cnt = STATS_INIT;
      #1;
      n_checks++;
      if ({o_valid, o_ready, o_busy, o_done, o_err, o_stall, o_fb_sel} !== 7'b0 || o_h_pow_pair !== '0)
         $display("FAIL drain_reset: got %b pair %h expected 0000000 pair 0",
                  {o_valid, o_ready, o_busy, o_done, o_err, o_stall, o_fb_sel}, o_h_pow_pair);
      else n_pass++;
      n_checks++;
      if (o_pair_count !== STATS_INIT) $display("FAIL drain_count: got %h expected %h", o_pair_count, STATS_INIT);
      else n_pass++;
      repeat (PIPE_LAT + 3) step();
      @(negedge i_clock);
      #1;
      n_checks++;
      if (done_q.size() !== 0 || o_ready !== 1'b0)
         $display("FAIL drain_nodone: got %0d done pulses ready %b expected 0 0", done_q.size(), o_ready);
      else n_pass++;
   endtask

   initial begin
      i_reset     = 1'b1;
      i_h_key     = '0;
      i_h_key2    = '0;
      i_key_load  = 1'b0;
      i_valid     = 1'b0;
      i_sop       = 1'b0;
      i_eop       = 1'b0;
      i_last_odd  = 1'b0;
      i_stall_req = 1'b0;
      key_a       = '0;
      key_b       = '0;
      test_reset();
      test_no_key();
`ifdef GHASH_SCHED_STATS_EN
      test_stats_wrap();
`endif
      test_three_pair();
      test_single_odd();
      test_stall();
      test_random();
      test_restart();
      test_bad_sop();
      test_reset_drain();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
